// File: rtl/cl_mcl_reg_endpoint.sv
// MCL request endpoint: decodes 80-bit request packets as register reads or
// writes against a local scratch register file plus a read-only packet
// counter, and returns read data or error responses through a 2-entry FIFO.
//
// Handshake semantics (both channels): a request transfers on a rising edge
// where v_i & ready_o; a response transfers on a rising edge where yumi_i is
// high, and yumi_i may only be raised while v_o is high. ready_o never depends
// on v_i, and v_o/data_o never depend on yumi_i.
module cl_mcl_reg_endpoint #(
  parameter int unsigned data_width_p = 80,
  parameter int unsigned els_p        = 16,
  parameter logic [7:0]  node_id_p    = 8'h00
) (
  input  logic                    clk_main_a0,
  input  logic                    rst_main_n,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [data_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [data_width_p-1:0] data_o,
  input  logic                    yumi_i,
  output logic [31:0]             pkt_count_o,
  output logic                    dbg_state_o
);

  if (data_width_p != 80) begin : g_bad_width
    $error("cl_mcl_reg_endpoint: data_width_p must be 80");
  end
  if (els_p < 2 || els_p > 256 || (els_p & (els_p - 1)) != 0) begin : g_bad_els
    $error("cl_mcl_reg_endpoint: els_p must be a power of 2 in 2..256");
  end

  localparam int unsigned idx_w   = $clog2(els_p);
  localparam logic [29:0] cnt_idx = 30'(els_p);
  localparam logic [7:0]  op_write = 8'h01;
  localparam logic [7:0]  op_read  = 8'h02;
  localparam logic [7:0]  op_rdrsp = 8'h03;
  localparam logic [7:0]  op_err   = 8'hFF;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  logic [1:0]  rst_sync_q;
  logic        rst_n;
  state_e      state_q, state_d;
  logic [79:0] req_q;
  logic [31:0] pkt_count_q;
  logic [31:0] regs_q [els_p];
  logic [79:0] fifo_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  fcnt_q;

  logic        ready_c, accept, full, deq, enq, reg_we;
  logic [79:0] enq_data;
  logic [7:0]  req_op;
  logic [31:0] req_addr;
  logic [29:0] word_idx;
  logic        is_scratch, is_counter;
  logic [idx_w-1:0] reg_idx;

  // Reset synchronizer: asserts immediately, releases two clocks after rst_main_n rises.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign req_op     = req_q[71:64];
  assign req_addr   = req_q[63:32];
  assign word_idx   = req_q[63:34];
  assign is_scratch = word_idx < cnt_idx;
  assign is_counter = word_idx == cnt_idx;
  assign reg_idx    = word_idx[idx_w-1:0];

  assign full   = fcnt_q == 2'd2;
  assign accept = v_i & ready_c;
  assign deq    = yumi_i & v_o;

  // Next-state and decode: IDLE waits for a request, ACCESS performs it in one cycle.
  always_comb begin
    state_d  = state_q;
    ready_c  = 1'b0;
    enq      = 1'b0;
    enq_data = '0;
    reg_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = rst_n & en_i & ~full;
        if (v_i && ready_c) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        if (req_op == op_write && (is_scratch || is_counter)) begin
          // Writes to the counter index are silently dropped.
          reg_we = is_scratch;
        end else if (req_op == op_read && (is_scratch || is_counter)) begin
          enq      = 1'b1;
          enq_data = {node_id_p, op_rdrsp, req_addr,
                      is_counter ? pkt_count_q : regs_q[reg_idx]};
        end else begin
          enq      = 1'b1;
          enq_data = {node_id_p, op_err, req_addr, 24'h0, req_op};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, request latch and accepted-packet counter.
  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q       <= data_i[79:0];
        pkt_count_q <= pkt_count_q + 32'd1;
      end
    end
  end

  // Scratch register file.
  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(els_p); i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[reg_idx] <= req_q[31:0];
    end
  end

  // Two-entry response FIFO; overflow is impossible because ready_o is gated on full.
  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      fcnt_q    <= 2'd0;
    end else begin
      if (enq) begin
        fifo_q[wr_ptr_q] <= enq_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      fcnt_q <= fcnt_q + {1'b0, enq} - {1'b0, deq};
    end
  end

  assign ready_o     = ready_c;
  assign v_o         = fcnt_q != 2'd0;
  assign data_o      = fifo_q[rd_ptr_q];
  assign pkt_count_o = pkt_count_q;
  assign dbg_state_o = state_q;

  a_yumi_only_when_valid: assert property (
    @(posedge clk_main_a0) disable iff (!rst_n) (yumi_i |-> v_o));

endmodule
